uart_tx: RTL

UART transmitter with a small input FIFO: accepts bytes over a valid/ready handshake, serialises them 8N1 (optionally 8E1) LSB-first on `tx`. Pairs with the existing UART receiver on the same `BAUD_DIV` and sits between the command/PWM logic and the serial pin. Back-to-back frames are emitted with no idle gap while the FIFO is non-empty.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Optional macro UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

    localparam int unsigned UART_DEFAULT_BAUD_DIV = 434;
    localparam int unsigned UART_DATA_BITS        = 8;
    localparam int unsigned UART_FRAME_BITS_8N1   = 10;
    localparam int unsigned UART_FRAME_BITS_8E1   = 11;

    // Codes are fixed explicitly so both ends agree whether or not PARITY exists.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO_DEPTH x 8 synchronous circular buffer with occupancy count.
// rd_data shows the head entry combinationally so a pop can load it the same cycle.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [UART_DATA_BITS-1:0]         wr_data,
    input  logic                              rd_en,
    output logic [UART_DATA_BITS-1:0]         rd_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic                      push;
    logic                      pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an LSB-first 8N1 serialiser on tx.
// Define UART_TX_PARITY_EN for an even parity bit after bit 7 (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    uart_state_e   state, state_d;
    logic [15:0]   baud_cnt, baud_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          load;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_valid),
        .wr_data (data_in),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign ready   = !fifo_full;
    assign busy    = (state != ST_IDLE) || (fifo_count != '0);
    assign tx      = tx_q;
    assign bit_end = (baud_cnt == 16'(BAUD_DIV - 1));

    // Next-state logic; tx_d is the line level for the cycle after the edge,
    // so the pin comes straight from a flop.
    always_comb begin
        state_d   = state;
        baud_d    = baud_cnt + 16'd1;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        tx_d      = tx_q;
        load      = 1'b0;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                load   = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                    tx_d    = shift[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d   = {1'b0, shift[7:1]};
                        bit_idx_d = bit_idx + 3'd1;
                        tx_d      = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    load    = !fifo_empty;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Shared frame launch from IDLE or straight out of STOP (no idle gap).
        if (load) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_rd_data;
            bit_idx_d = '0;
            baud_d    = '0;
            state_d   = ST_START;
            tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d  = even_parity(fifo_rd_data);
`endif
        end
    end

    // State, counters, shifter and the registered line driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
